instr_mem_arbiter: RTL

INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

---
 rtl/instruction_package.sv | 26 ++
 rtl/rr_priority_encoder.sv | 36 +++
 rtl/instr_mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/instruction_package.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instruction_package: regex-core instruction word layout and types |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package instruction_package;

   localparam int INSTRUCTION_WIDTH      = 16;
   localparam int INSTRUCTION_TYPE_START = 13;
   localparam int INSTRUCTION_TYPE_END   = 15;
   localparam int INSTRUCTION_TYPE_WIDTH = INSTRUCTION_TYPE_END - INSTRUCTION_TYPE_START + 1;

   // Three-bit opcode field; all eight encodings are legal.
   typedef enum logic [INSTRUCTION_TYPE_WIDTH-1:0] {
      ACCEPT                = 3'd0,
      SPLIT                 = 3'd1,
      MATCH                 = 3'd2,
      JMP                   = 3'd3,
      END_WITHOUT_ACCEPTING = 3'd4,
      MATCH_ANY             = 3'd5,
      ACCEPT_PARTIAL        = 3'd6,
      NOT_MATCH             = 3'd7
   } instr_type;

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_priority_encoder: first asserted request at or after ptr, wrap  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_priority_encoder #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   int j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_mem_arbiter: round-robin shared instruction-memory fetch     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_mem_arbiter
   import instruction_package::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PC_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*PC_WIDTH-1:0]   req_pc,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          mem_en,
   output logic [PC_WIDTH-1:0]           mem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0]  mem_rdata,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [INSTRUCTION_WIDTH-1:0]  resp_instr,
   output instr_type                     resp_itype,
   input  logic [NUM_REQ-1:0]            resp_ready
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      RESP     = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             ptr_q, ptr_d;
   logic [IDX_W-1:0]             grant_q, grant_d;
   logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;

   logic [NUM_REQ-1:0]           win_onehot;
   logic [IDX_W-1:0]             win_idx;
   logic                         win_any;

   rr_priority_encoder #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (win_onehot),
      .idx_o   (win_idx),
      .any_o   (win_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      instr_d    = instr_q;
      req_ready  = '0;
      mem_en     = 1'b0;
      mem_addr   = '0;
      resp_valid = '0;
      case (state_q)
         IDLE: begin
            // Grant outputs are combinational, so they must be masked while reset is held.
            if (win_any && !rst) begin
               req_ready = win_onehot;
               mem_en    = 1'b1;
               mem_addr  = req_pc[win_idx*PC_WIDTH +: PC_WIDTH];
               grant_d   = win_idx;
               ptr_d     = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
               state_d   = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            instr_d = mem_rdata;
            state_d = RESP;
         end
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_instr = instr_q;
   assign resp_itype = instr_type'(instr_q[INSTRUCTION_TYPE_END:INSTRUCTION_TYPE_START]);

endmodule
`default_nettype wire
